// File: rtl/hazard_unit.sv
// Decode-side hazard unit: tracks in-flight destination registers in a three-entry
// scoreboard (EX, MEM, WB) and derives bypass selects, load-use stalls and curr_rd.
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             we_stall,
  output logic             we_bypass,
  output logic [1:0]       fwd_rs1,
  output logic [1:0]       fwd_rs2,
  output logic [4:0]       curr_rd,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } sb_entry_t;

  sb_entry_t ex_q, mem_q, wb_q;
  sb_entry_t ex_d;
  logic      load_hit_rs1, load_hit_rs2;
  logic      unused_wb_ld;

  // The load flag only matters while the entry sits in EX.
  assign unused_wb_ld = wb_q.ld;

  function automatic logic writes_reg(input sb_entry_t e, input logic [4:0] r);
    return e.v && e.we && (e.rd == r) && (r != 5'd0);
  endfunction

  // Youngest producer wins; a load still in EX has no data yet, so look past it.
  function automatic logic [1:0] operand_select(input logic valid, input logic uses,
                                                input logic [4:0] rs,
                                                input sb_entry_t ex,
                                                input sb_entry_t mem,
                                                input sb_entry_t wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (valid && uses && (rs != 5'd0)) begin
      if (writes_reg(ex, rs) && !ex.ld) begin
        sel = 2'b01;
      end else if (writes_reg(mem, rs)) begin
        sel = 2'b10;
      end else if (writes_reg(wb, rs)) begin
        sel = 2'b11;
      end
    end
    return sel;
  endfunction

  always_comb begin
    load_hit_rs1 = id_uses_rs1 && (id_rs1 == ex_q.rd);
    load_hit_rs2 = id_uses_rs2 && (id_rs2 == ex_q.rd);
    we_stall     = id_valid && !flush && ex_q.v && ex_q.ld && ex_q.we &&
                   (ex_q.rd != 5'd0) && (load_hit_rs1 || load_hit_rs2);

    fwd_rs1   = operand_select(id_valid, id_uses_rs1, id_rs1, ex_q, mem_q, wb_q);
    fwd_rs2   = operand_select(id_valid, id_uses_rs2, id_rs2, ex_q, mem_q, wb_q);
    we_bypass = (fwd_rs1 != 2'b00) || (fwd_rs2 != 2'b00);
    curr_rd   = ex_q.v ? ex_q.rd : 5'd0;

    // Stalled or squashed decode instructions enter EX as a bubble.
    ex_d = '0;
    if (id_valid && !we_stall && !flush) begin
      ex_d = '{v: 1'b1, rd: id_rd, we: id_we, ld: id_is_load};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (we_stall && (stall_count != '1)) begin
      stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard unit that sits alongside the decode stage and drives the `Flags` sink side of `DataPath`. It tracks the destination register of every instruction in EX, MEM and WB with a three-entry shift scoreboard. From that scoreboard it produces per-operand bypass selects, a load-use stall and the `curr_rd` that `DataPath` consumes. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- `CNT_W`, default 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  decode stage holds a real instruction.
- `id_rs1`, `id_rs2`  in  5 each  source register indices of the decode instruction.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  the instruction actually reads that operand.
- `id_rd`  in  5  destination index of the decode instruction.
- `id_we`  in  1  the decode instruction writes `id_rd`.
- `id_is_load`  in  1  the decode instruction is a load.
- `flush`  in  1  taken branch or jump resolved in EX; the decode instruction is squashed.
- `we_stall`  out  1  hold IF/ID and insert a bubble into EX.
- `we_bypass`  out  1  OR of (`fwd_rs1 != 0`) and (`fwd_rs2 != 0`).
- `fwd_rs1`, `fwd_rs2`  out  2 each  operand source select: 00 register file, 01 EX result, 10 MEM result (ALU or load data), 11 WB result.
- `curr_rd`  out  5  rd of the EX entry; 0 when EX is invalid.
- `stall_count`  out  CNT_W  number of cycles in which `we_stall` was 1, saturating.

## Operation
- Scoreboard entries EX, MEM and WB each hold {v, rd, we, ld}.
- An entry "writes r" when v=1, we=1, rd=r and r≠0.
- Stall (combinational):
  - `we_stall` = `id_valid` & !`flush` & EX.v & EX.ld & EX.we & EX.rd≠0 & ((`id_uses_rs1` & `id_rs1`==EX.rd) | (`id_uses_rs2` & `id_rs2`==EX.rd)).
- Forward select (combinational, per operand, priority EX > MEM > WB):
  - 01 if EX writes rs and EX.ld=0.
  - else 10 if MEM writes rs.
  - else 11 if WB writes rs.
  - else 00.
  - Forced to 00 when `id_valid`=0, when the operand is unused, or when rs=0.
  - When EX is a load matching rs, the EX term is skipped. The stall covers that cycle.
- Scoreboard shift on every clock edge:
  - WB ← MEM, and MEM ← EX.
  - EX ← {`id_valid`, `id_rd`, `id_we`, `id_is_load`} when `id_valid` & !`we_stall` & !`flush`.
  - Otherwise EX ← bubble (v=0).
- `flush` overrides `we_stall`: the squashed instruction never stalls.
- Stall counter:
  - `stall_count` increments when `we_stall`=1.
  - It holds at all-ones once saturated.
  - It does not wrap.
- x0 is never a hazard. Writes to rd=0 are recorded but never match.

## Timing
- All outputs except `stall_count` are combinational from the ID inputs and registered scoreboard state. They are valid in the same cycle as the ID inputs.
- `stall_count` is registered. It reflects a stall one cycle after that stall is observed.
- A load followed immediately by a dependent instruction gives exactly one stall cycle. In the next cycle the load is in MEM and the select is 10.
- Dependency distance 1 (non-load) gives 01, distance 2 gives 10, and distance 3 gives 11. At distance ≥4 the select is 00; the register file is write-before-read.
- Reset state, asynchronous and immediate on `rst`=1:
  - All v=0.
  - `we_stall`=0, `we_bypass`=0, `fwd_rs1`=`fwd_rs2`=00, `curr_rd`=0, `stall_count`=0.
  - Reset mid-stall drops the stall in the same cycle, with no clock edge needed.
- First edge after `rst` deasserts: EX captures the ID inputs normally.
- Simultaneous `flush` and a load-use condition: no stall, EX ← bubble, and the counter is not incremented.

## Test plan
- ALU chain: `add x5` in ID at cycle n, then ID `rs1=5` at n+1. Expect `fwd_rs1`=01, `we_bypass`=1, `curr_rd`=5, `we_stall`=0.
- Load-use: `lw x6` at n, then ID `rs2=6` at n+1.
  - n+1: `we_stall`=1.
  - n+2: `we_stall`=0 and `fwd_rs2`=10.
  - n+3: `stall_count`=1.
- Priority and distance:
  - `add x7` at n, `add x7` at n+1, ID `rs1=7` at n+2: expect 01.
  - `add x8` at n, two independent instructions, ID `rs2=8` at n+3: expect 11.
  - Same pattern but ID `rs2=8` at n+4: expect 00.
- x0 and unused operands:
  - Writer rd=0 followed by ID `rs1=0`: expect 00 with no stall.
  - Writer x9 followed by ID `rs1=9` with `id_uses_rs1`=0: expect 00.
- Flush vs stall: load-use condition with `flush`=1. Expect `we_stall`=0, `curr_rd`=0 next cycle, and `stall_count` unchanged.
- Reset: assert `rst` asynchronously while `we_stall`=1 and `stall_count`=5. Expect all outputs 0 before the next edge. Force the counter to all-ones and hold the stall: expect the counter to stay all-ones.
